// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory boot loader:
// loader state encoding and frame byte order.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } load_state_t;

    // Payload words arrive MSB first, so byte 0 of a word lands in lane 3 ([31:24]).
    localparam logic [1:0] FIRST_BYTE_LANE = 2'd3;

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects four stream bytes into one 32-bit word and flags the cycle in
// which the fourth byte arrives, presenting the completed word combinationally.
module byte_to_word_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic [1:0]  w_lane;

    assign w_lane = FIRST_BYTE_LANE - r_byte_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_byte_valid) begin
            r_word[{w_lane, 3'b000} +: 8] <= i_byte;
            r_byte_idx                    <= r_byte_idx + 2'd1;
        end
    end

    // The last byte is merged in directly so the word is ready the cycle it arrives.
    always_comb begin
        o_word                        = r_word;
        o_word[{w_lane, 3'b000} +: 8] = i_byte;
    end

    assign o_word_done = i_byte_valid && (r_byte_idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the MIPS core in reset until a complete, verified image is present.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    load_state_t       r_state;
    load_state_t       w_next;

    logic              w_xfer;
    logic              w_start_ok;
    logic              w_word_done;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic [15:0]       w_len_rx;

    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [7:0]        r_xor;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_word_count;

    assign w_xfer      = in_valid && in_ready;
    assign w_start_ok  = start && (r_state inside {IDLE, DONE, ERROR});
    assign w_len_rx    = {r_len_hi, in_data};
    assign w_last_word = (r_word_count == r_len - 16'd1);

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_byte_valid (w_xfer && (r_state == DATA)),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_done  (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) w_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_rx > 16'(MAX_WORDS)) w_next = ERROR;
                    else if (w_len_rx == 16'd0)    w_next = CSUM;
                    else                           w_next = DATA;
                end
            end
            DATA: begin
                if (w_word_done && w_last_word) w_next = CSUM;
            end
            CSUM: begin
                if (w_xfer) w_next = (in_data == r_xor) ? DONE : ERROR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = r_state inside {LEN_HI, LEN_LO, DATA, CSUM};
    end

    // Status flags follow the state being entered, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_hi     <= 8'd0;
            r_len        <= 16'd0;
            r_xor        <= 8'd0;
            r_im_we      <= 1'b0;
            r_im_addr    <= '0;
            r_im_wdata   <= 32'd0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_xor        <= 8'd0;
                r_word_count <= 16'd0;
            end
            if (w_xfer && (r_state == LEN_HI)) r_len_hi <= in_data;
            if (w_xfer && (r_state == LEN_LO)) r_len    <= w_len_rx;
            if (w_xfer && (r_state == DATA))   r_xor    <= r_xor ^ in_data;
            r_im_we <= w_word_done;
            if (w_word_done) begin
                r_im_addr    <= r_word_count[ADDR_W-1:0];
                r_im_wdata   <= w_word;
                r_word_count <= r_word_count + 16'd1;
            end
            r_cpu_rst <= (w_next != DONE);
            r_done    <= (w_next == DONE);
            r_error   <= (w_next == ERROR);
        end
    end

    assign im_we      = r_im_we;
    assign im_addr    = r_im_addr;
    assign im_wdata   = r_im_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule
